opb_register_simulink2ppc_snap: RTL



---
 rtl/opb_s2p_pkg.sv | 33 +++
 rtl/opb_s2p_bus_fsm.sv | 69 ++++++
 rtl/opb_register_simulink2ppc_snap.sv | 118 +++++++++++
 3 files changed

// File: rtl/opb_s2p_pkg.sv
// Shared definitions for the Simulink-to-PPC snapshot register: word offsets, field positions, bus states.
// Pure declarations, no timing; status word packing lives here so every reader sees the same layout.
package opb_s2p_pkg;

    localparam int CNT_W = 16;

    // Word offsets within the 256-byte window (byte offset >> 2)
    localparam logic [5:0] OFF_DATA   = 6'd0;
    localparam logic [5:0] OFF_STATUS = 6'd1;
    localparam logic [5:0] OFF_CTRL   = 6'd2;

    localparam int ST_FRESH    = 0;
    localparam int ST_OVERRUN  = 1;
    localparam int ST_CNT_LSB  = 16;
    localparam int CTRL_FREEZE = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } bus_state_t;

    function automatic logic [31:0] pack_status(input logic fresh, input logic overrun,
                                                input logic [CNT_W-1:0] count);
        logic [31:0] w;
        w = '0;
        w[ST_FRESH] = fresh;
        w[ST_OVERRUN] = overrun;
        w[ST_CNT_LSB +: CNT_W] = count;
        return w;
    endfunction

endpackage

// File: rtl/opb_s2p_bus_fsm.sv
// OPB slave front end: window decode, one ack per select assertion, read data forced to zero off-ack.
// Ack arrives one cycle after the hit; holds in WAIT until select drops, so a held select never re-acks.
module opb_s2p_bus_fsm
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] BASEADDR = 32'h0108F300,
    parameter logic [31:0] HIGHADDR = 32'h0108F3FF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        select,
    input  logic        rnw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_word,
    output logic        req,
    output logic [5:0]  req_off,
    output logic        ack,
    output logic        acc_rnw,
    output logic [5:0]  acc_off,
    output logic [31:0] acc_wdata,
    output logic [31:0] bus_dat
);

    bus_state_t  state, state_nxt;
    logic        hit;
    logic [31:0] byte_off;
    logic        unused_ok;

    assign byte_off  = addr - BASEADDR;
    assign req_off   = byte_off[7:2];
    assign hit       = select && (addr >= BASEADDR) && (addr <= HIGHADDR);
    assign unused_ok = ^{byte_off[31:8], byte_off[1:0]};

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        case (state)
            IDLE: if (hit) begin
                req       = 1'b1;
                state_nxt = ACK;
            end
            ACK:  state_nxt = WAIT;
            WAIT: if (!select) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ack     = (state == ACK);
    assign bus_dat = ack ? rd_word : '0;

    // Capture the request so the write lands in the ACK cycle regardless of what the master does next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_rnw   <= 1'b1;
            acc_off   <= '0;
            acc_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (req) begin
                acc_rnw   <= rnw;
                acc_off   <= req_off;
                acc_wdata <= wdata;
            end
        end
    end

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// Holds a user-strobed 32-bit sample with fresh/overrun/count/freeze for PPC reads over OPB.
// Read data registered at hit, returned on the following ack cycle; user capture is a single-cycle strobe.
module opb_register_simulink2ppc_snap
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0108F300,
    parameter logic [31:0] C_HIGHADDR   = 32'h0108F3FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_valid,
    output logic                    user_fresh
);

    // Ascending bus vectors assign positionally, giving bus bit i <-> register bit 31-i
    logic [31:0] addr, wdata, bus_dat;
    logic        req, ack, acc_rnw;
    logic [5:0]  req_off, acc_off;
    logic [31:0] acc_wdata, rd_word;

    logic [31:0]      data;
    logic             fresh, overrun, freeze;
    logic [CNT_W-1:0] count;
    logic             data_rd, status_wr, ctrl_wr, capture;
    logic             unused_ok;

    assign addr  = OPB_ABus;
    assign wdata = OPB_DBus;

    opb_s2p_bus_fsm #(
        .BASEADDR (C_BASEADDR),
        .HIGHADDR (C_HIGHADDR)
    ) u_bus (
        .clk       (OPB_Clk),
        .rst_n     (OPB_Rst_n),
        .select    (OPB_select),
        .rnw       (OPB_RNW),
        .addr      (addr),
        .wdata     (wdata),
        .rd_word   (rd_word),
        .req       (req),
        .req_off   (req_off),
        .ack       (ack),
        .acc_rnw   (acc_rnw),
        .acc_off   (acc_off),
        .acc_wdata (acc_wdata),
        .bus_dat   (bus_dat)
    );

    assign Sl_DBus    = bus_dat;
    assign Sl_xferAck = ack;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign user_fresh = fresh;
    assign unused_ok  = ^{OPB_BE, OPB_seqAddr, (C_FAMILY != 0)};

    assign data_rd   = ack &&  acc_rnw && (acc_off == OFF_DATA);
    assign status_wr = ack && !acc_rnw && (acc_off == OFF_STATUS);
    assign ctrl_wr   = ack && !acc_rnw && (acc_off == OFF_CTRL);
    assign capture   = user_valid && !freeze;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            data    <= '0;
            fresh   <= 1'b0;
            overrun <= 1'b0;
            count   <= '0;
            freeze  <= 1'b0;
        end else begin
            if (capture) data <= user_data_in;

            // A new sample outranks a concurrent DATA read clearing the flag
            if (capture)      fresh <= 1'b1;
            else if (data_rd) fresh <= 1'b0;

            // Software clear outranks a concurrent strobe
            if (status_wr) begin
                overrun <= 1'b0;
                count   <= '0;
            end else if (user_valid) begin
                if (freeze || fresh) overrun <= 1'b1;
                if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
            end

            if (ctrl_wr) freeze <= acc_wdata[CTRL_FREEZE];
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            rd_word <= '0;
        end else if (req) begin
            case (req_off)
                OFF_DATA:   rd_word <= data;
                OFF_STATUS: rd_word <= pack_status(fresh, overrun, count);
                OFF_CTRL:   rd_word <= {31'd0, freeze};
                default:    rd_word <= '0;
            endcase
        end
    end

endmodule
